// File: rtl/mac_pipe_sat.sv
// rtl/mac_pipe_sat.sv - pipelined signed multiply-accumulate with rounding shift and saturation
module mac_pipe_sat #(
  parameter int A_W       = 32,
  parameter int B_W       = 32,
  parameter int C_W       = 64,
  parameter int P_W       = 64,
  parameter int PIPE_MULT = 2,
  parameter int SHIFT     = 0,
  parameter int SATURATE  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  in_valid,
  input  logic [1:0]            mode,
  input  logic signed [A_W-1:0] a,
  input  logic signed [B_W-1:0] b,
  input  logic signed [C_W-1:0] c,
  input  logic                  ovf_clr,
  output logic                  out_valid,
  output logic signed [P_W-1:0] p,
  output logic                  ovf
);

  localparam logic [1:0] M_ACC  = 2'd1;
  localparam logic [1:0] M_LOAD = 2'd2;
  localparam logic [1:0] M_MSUB = 2'd3;
  localparam int         LST    = PIPE_MULT - 1;

  localparam logic signed [C_W-1:0] C_MAX = {1'b0, {(C_W-1){1'b1}}};
  localparam logic signed [C_W-1:0] C_MIN = {1'b1, {(C_W-1){1'b0}}};
  localparam logic signed [P_W-1:0] P_MAX = {1'b0, {(P_W-1){1'b1}}};
  localparam logic signed [P_W-1:0] P_MIN = {1'b1, {(P_W-1){1'b0}}};

  logic signed [A_W-1:0] a_r;
  logic signed [B_W-1:0] b_r;
  logic signed [C_W-1:0] c_r;
  logic [1:0]            m_r;
  logic                  v_r;

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_r <= '0;
      b_r <= '0;
      c_r <= '0;
      m_r <= '0;
      v_r <= 1'b0;
    end else if (enable) begin
      a_r <= a;
      b_r <= b;
      c_r <= c;
      m_r <= mode;
      v_r <= in_valid;
    end
  end

  logic signed [A_W+B_W-1:0] prod_full;
  logic signed [C_W-1:0]     pm_prod [PIPE_MULT];
  logic signed [C_W-1:0]     pm_c    [PIPE_MULT];
  logic [1:0]                pm_mode [PIPE_MULT];
  logic                      pm_v    [PIPE_MULT];

  assign prod_full = a_r * b_r;

  // c and mode ride alongside the product so each sample stays self-contained
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < PIPE_MULT; i++) begin
        pm_prod[i] <= '0;
        pm_c[i]    <= '0;
        pm_mode[i] <= '0;
        pm_v[i]    <= 1'b0;
      end
    end else if (enable) begin
      pm_prod[0] <= C_W'(prod_full);
      pm_c[0]    <= c_r;
      pm_mode[0] <= m_r;
      pm_v[0]    <= v_r;
      for (int i = 1; i < PIPE_MULT; i++) begin
        pm_prod[i] <= pm_prod[i-1];
        pm_c[i]    <= pm_c[i-1];
        pm_mode[i] <= pm_mode[i-1];
        pm_v[i]    <= pm_v[i-1];
      end
    end
  end

  logic signed [C_W-1:0] acc;
  logic signed [C_W-1:0] add_base;
  logic signed [C_W:0]   sum;
  logic signed [C_W-1:0] sum_n;
  logic                  add_ovf;

  always_comb begin
    add_base = (pm_mode[LST] == M_ACC) ? acc : pm_c[LST];
    if (pm_mode[LST] == M_MSUB)
      sum = (C_W+1)'(add_base) - (C_W+1)'(pm_prod[LST]);
    else
      sum = (C_W+1)'(add_base) + (C_W+1)'(pm_prod[LST]);
    add_ovf = sum[C_W] ^ sum[C_W-1];
    sum_n   = sum[C_W-1:0];
    if (add_ovf && SATURATE != 0)
      sum_n = sum[C_W] ? C_MIN : C_MAX;
  end

  logic signed [C_W-1:0] s_r;
  logic                  s_v;
  logic                  s_ovf;

  // acc is read combinationally above, so back-to-back ACC samples see the latest value
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc   <= '0;
      s_r   <= '0;
      s_v   <= 1'b0;
      s_ovf <= 1'b0;
    end else if (enable) begin
      s_r   <= sum_n;
      s_v   <= pm_v[LST];
      s_ovf <= pm_v[LST] & add_ovf;
      if (pm_v[LST] && (pm_mode[LST] == M_ACC || pm_mode[LST] == M_LOAD))
        acc <= sum_n;
    end
  end

  logic signed [C_W:0] t;

  if (SHIFT > 0) begin : g_shift
    localparam logic signed [C_W:0] RND = (C_W+1)'(1) << (SHIFT - 1);
    assign t = ((C_W+1)'(s_r) + RND) >>> SHIFT;
  end else begin : g_noshift
    assign t = (C_W+1)'(s_r);
  end

  logic signed [P_W-1:0] t_lo;
  logic signed [P_W-1:0] p_n;
  logic                  out_ovf;

  always_comb begin
    t_lo    = t[P_W-1:0];
    out_ovf = (t != (C_W+1)'(t_lo));
    p_n     = t_lo;
    if (out_ovf && SATURATE != 0)
      p_n = t[C_W] ? P_MIN : P_MAX;
  end

  // ovf_clr is honoured even while stalled; a simultaneous set takes priority
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      p         <= '0;
      ovf       <= 1'b0;
    end else begin
      if (enable) begin
        out_valid <= s_v;
        if (s_v)
          p <= p_n;
      end
      if (enable && s_v && (s_ovf || out_ovf))
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_pipe_sat.sv
// tb/tb_mac_pipe_sat.sv - self-checking bench for mac_pipe_sat (default and SHIFT=4/P_W=16 instances)
module tb_mac_pipe_sat;

  logic               clk = 1'b0;
  logic               reset, enable, in_valid, ovf_clr;
  logic [1:0]         mode;
  logic signed [31:0] a, b;
  logic signed [63:0] c;
  logic               ov0, ovf0, ov1, ovf1;
  logic [63:0]        p0;
  logic [15:0]        p1;

  always #5 clk = ~clk;

  mac_pipe_sat dut0 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .mode(mode),
    .a(a), .b(b), .c(c), .ovf_clr(ovf_clr), .out_valid(ov0), .p(p0), .ovf(ovf0)
  );

  mac_pipe_sat #(.SHIFT(4), .P_W(16)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .mode(mode),
    .a(a), .b(b), .c(c), .ovf_clr(ovf_clr), .out_valid(ov1), .p(p1), .ovf(ovf1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: results computed arithmetically at acceptance, released 4 enabled edges later
  typedef struct {
    logic signed [127:0] x;
    bit                  aovf;
    int                  due;
  } ent_t;

  ent_t                q[$];
  logic signed [127:0] macc;
  int                  en_cnt = 0;
  int                  cyc = 0;
  bit                  e_ov;
  logic signed [127:0] e_p0, e_p1;
  bit                  e_ovf0, e_ovf1;

  function automatic logic signed [127:0] out_model(input logic signed [127:0] x, input int s,
                                                    input int pw, output bit o);
    logic signed [127:0] y, one, hi, lo;
    one = 1;
    y   = x;
    if (s > 0) y = (x + (one <<< (s - 1))) >>> s;
    hi = (one <<< (pw - 1)) - one;
    lo = -(one <<< (pw - 1));
    o  = 1'b0;
    if (y > hi) begin y = hi; o = 1'b1; end
    else if (y < lo) begin y = lo; o = 1'b1; end
    return y;
  endfunction

  always @(posedge clk) begin
    logic signed [127:0] pa, pb, pc, base, sum, one, hi, lo;
    ent_t e;
    bit   s0, s1, o0, o1;
    cyc++;
    if (!reset) begin
      q.delete();
      macc = 0; e_ov = 0; e_p0 = 0; e_p1 = 0; e_ovf0 = 0; e_ovf1 = 0;
    end else begin
      s0 = 0; s1 = 0;
      if (enable) begin
        en_cnt++;
        if (in_valid) begin
          one = 1; hi = (one <<< 63) - one; lo = -(one <<< 63);
          pa = a; pb = b; pc = c;
          base = (mode == 2'd1) ? macc : pc;
          sum  = (mode == 2'd3) ? base - pa * pb : base + pa * pb;
          e.aovf = (sum > hi) || (sum < lo);
          e.x    = (sum > hi) ? hi : (sum < lo) ? lo : sum;
          e.due  = en_cnt + 4;
          if (mode == 2'd1 || mode == 2'd2) macc = e.x;
          q.push_back(e);
        end
        e_ov = 0;
        if (q.size() > 0 && q[0].due == en_cnt) begin
          e = q.pop_front();
          e_ov = 1;
          e_p0 = out_model(e.x, 0, 64, o0);
          e_p1 = out_model(e.x, 4, 16, o1);
          s0 = e.aovf | o0;
          s1 = e.aovf | o1;
        end
      end
      if (s0) e_ovf0 = 1; else if (ovf_clr) e_ovf0 = 0;
      if (s1) e_ovf1 = 1; else if (ovf_clr) e_ovf1 = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("out_valid0", ov0, e_ov);
    chk("p0", p0, e_p0[63:0]);
    chk("ovf0", ovf0, e_ovf0);
    chk("out_valid1", ov1, e_ov);
    chk("p1", p1, e_p1[15:0]);
    chk("ovf1", ovf1, e_ovf1);
  end

  // Log of results accepted by a consumer (out_valid on an enabled edge)
  logic [63:0] obs[$];
  logic [15:0] obs1[$];
  int          obs_t[$];

  always @(posedge clk) begin
    bit en_s, rs_s;
    en_s = enable;
    rs_s = reset;
    #1;
    if (rs_s && en_s && ov0) begin obs.push_back(p0); obs_t.push_back(cyc); end
    if (rs_s && en_s && ov1) obs1.push_back(p1);
  end

  task automatic drive(input bit v, input logic [1:0] m, input logic signed [31:0] aa,
                       input logic signed [31:0] bb, input logic signed [63:0] cc);
    in_valid = v; mode = m; a = aa; b = bb; c = cc;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) @(negedge clk);
  endtask

  localparam logic signed [31:0] MIN32 = 32'sh8000_0000;

  initial begin
    int n, n1, n2, t_in, ts1, ts2;
    logic [63:0] ev;
    reset = 0; enable = 1; in_valid = 0; ovf_clr = 0; mode = 0; a = 0; b = 0; c = 0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", ov0, 1'b0);
    chk("reset_p", p0, 64'd0);
    chk("reset_ovf", ovf0, 1'b0);
    reset = 1;
    idle(2);

    n = obs.size();
    drive(1, 2'd0, 3, -4, 100);
    t_in = cyc;
    drive(1, 2'd3, 3, -4, 100);
    idle(8);
    chk("madd_p", obs[n], 64'd88);
    chk("msub_p", obs[n+1], 64'd112);
    chk("madd_latency", obs_t[n] - t_in, 4);
    chk("msub_next_cycle", obs_t[n+1] - obs_t[n], 1);

    n = obs.size();
    drive(1, 2'd2, 0, 0, 0);
    repeat (4) drive(1, 2'd1, 1000, 1000, 0);
    drive(1, 2'd0, 5, 5, 7);
    drive(1, 2'd1, 1, 1, 0);
    idle(8);
    chk("acc_load", obs[n], 64'd0);
    chk("acc_1", obs[n+1], 64'd1000000);
    chk("acc_4", obs[n+4], 64'd4000000);
    chk("acc_consecutive", obs_t[n+4] - obs_t[n], 4);
    chk("madd_mid", obs[n+5], 64'd32);
    chk("acc_after_madd", obs[n+6], 64'd4000001);

    n = obs.size();
    drive(1, 2'd2, MIN32, MIN32, 0);
    drive(1, 2'd1, MIN32, MIN32, 0);
    idle(8);
    chk("load_2p62", obs[n], 64'h4000_0000_0000_0000);
    chk("acc_sat", obs[n+1], 64'h7fff_ffff_ffff_ffff);
    chk("sat_ovf", ovf0, 1'b1);
    idle(3);
    chk("ovf_sticky", ovf0, 1'b1);
    ovf_clr = 1; idle(1); ovf_clr = 0;
    chk("ovf_cleared", ovf0, 1'b0);
    drive(1, 2'd1, MIN32, MIN32, 0);
    idle(3);
    chk("ovf_before_set", ovf0, 1'b0);
    ovf_clr = 1; idle(1); ovf_clr = 0;
    chk("ovf_set_wins", ovf0, 1'b1);
    idle(4);

    ovf_clr = 1; idle(1); ovf_clr = 0;
    n = obs1.size();
    drive(1, 2'd0, 1, 24, 0);
    drive(1, 2'd0, 1, -24, 0);
    idle(6);
    chk("shift_ovf_clear", ovf1, 1'b0);
    drive(1, 2'd0, 1, 32'sd1048576, 0);
    idle(8);
    chk("shift_round_up", obs1[n], 16'd2);
    chk("shift_neg", obs1[n+1], 16'hffff);
    chk("shift_sat", obs1[n+2], 16'd32767);
    chk("shift_sat_ovf", ovf1, 1'b1);

    n1 = obs.size();
    for (int i = 0; i < 8; i++) begin
      drive(1, 2'd0, i + 1, -7 * i, 1000 * i);
      if (i == 0) ts1 = cyc;
    end
    idle(10);
    n2 = obs.size();
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        enable = 0; in_valid = 1; a = 99; b = 99;
        repeat (3) @(negedge clk);
        enable = 1;
      end
      drive(1, 2'd0, i + 1, -7 * i, 1000 * i);
      if (i == 0) ts2 = cyc;
    end
    idle(10);
    chk("stall_count", obs.size() - n2, 8);
    for (int i = 0; i < 8; i++) begin
      ev = 64'(longint'((i + 1) * (-7 * i) + 1000 * i));
      chk($sformatf("stall_p%0d", i), obs[n2+i], ev);
    end
    chk("stall_delay", (obs_t[n2+7] - ts2) - (obs_t[n1+7] - ts1), 3);

    repeat (3) drive(1, 2'd1, 5, 5, 0);
    reset = 0; in_valid = 1; mode = 2'd2; a = 7; b = 7; c = 9;
    @(negedge clk);
    reset = 1;
    chk("rst_mid_valid", ov0, 1'b0);
    chk("rst_mid_p", p0, 64'd0);
    chk("rst_mid_ovf", ovf0, 1'b0);
    n = obs.size();
    drive(1, 2'd1, 2, 3, 0);
    idle(8);
    chk("rst_only_one_out", obs.size() - n, 1);
    chk("rst_acc_cleared", obs[n], 64'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_pipe_sat.md
Name: mac_pipe_sat

Overview:
Parametrised, pipelined signed multiply-accumulate unit with a valid-qualified datapath. It supports four operation modes, an internal accumulator, a rounded arithmetic output shift and saturation with a sticky overflow flag. It is the general MAC engine for the IIR/integrator and filter datapaths, replacing fixed 32x32+64 MAC instances.

Parameters:
A_W, 32, signed width of operand a
B_W, 32, signed width of operand b
C_W, 64, signed width of addend c and of the accumulator; must be >= A_W+B_W
P_W, 64, signed output width; must be <= C_W
PIPE_MULT, 2, product pipeline stages, legal range 1..4
SHIFT, 0, arithmetic right shift applied at output, range 0..C_W-1
SATURATE, 1, 1 = saturate at accumulator and output, 0 = two's-complement wrap

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset; reset=0 clears the block
enable  in  1  pipeline clock enable; 0 = stall
in_valid  in  1  a/b/c/mode qualify a sample
mode  in  2  0 MADD p=a*b+c; 1 ACC acc+=a*b; 2 LOAD acc=c+a*b; 3 MSUB p=c-a*b
a  in  A_W  signed multiplicand
b  in  B_W  signed multiplier
c  in  C_W  signed addend, used in modes 0, 2 and 3
ovf_clr  in  1  clears the sticky ovf flag
out_valid  out  1  p holds a result
p  out  P_W  signed result
ovf  out  1  sticky overflow/saturation flag

Behaviour:
- Pipeline: input register (1) -> product stages (PIPE_MULT) -> add/accumulate stage (1) -> shift/saturate output register (1).
- Latency L = PIPE_MULT+3 enabled cycles. Default L = 5.
- Valid tracking: a valid bit travels with each sample. in_valid=0 inserts a bubble, and a bubble never modifies acc or ovf.
- Stall (enable=0): every pipeline register, valid bit and acc holds its value. p and out_valid hold. ovf_clr still acts during a stall.
- Product: the full A_W+B_W signed product is sign-extended to C_W. The product never overflows.
- Add stage sum, computed at C_W+1 bits:
  - MADD: c+prod
  - MSUB: c-prod
  - ACC: acc+prod
  - LOAD: c+prod
- acc update: ACC and LOAD write the sum into acc. MADD and MSUB leave acc unchanged. All modes forward the sum to the output stage.
- Narrowing to C_W: with SATURATE=1 the sum clamps to [-2^(C_W-1), 2^(C_W-1)-1]. With SATURATE=0 it wraps. Either way an out-of-range sum sets ovf.
- Accumulator feedback: acc feeds back within the add stage, so back-to-back ACC samples in consecutive cycles accumulate correctly with no hazard.
- Output stage:
  - SHIFT>0: add 2^(SHIFT-1) (round half up), then arithmetic shift right by SHIFT.
  - Narrow to P_W by saturating (SATURATE=1) or truncating (SATURATE=0). An out-of-range value sets ovf.
- ovf:
  - Set only by valid samples.
  - Cleared by ovf_clr=1.
  - If a set and ovf_clr occur in the same cycle, set wins (ovf=1).
- Reset (reset=0): all pipeline registers, acc, p, out_valid and ovf go to 0 on the next edge, regardless of enable. In-flight samples are discarded. No output is produced for inputs presented while reset=0.
- Mode is captured with the sample and travels with it. Mixed-mode streams are legal, e.g. LOAD followed by ACC in the next cycle uses the freshly loaded acc.

Test Plan:
1. Default params, MADD, a=3, b=-4, c=100, one valid cycle -> exactly 5 cycles later out_valid=1 for 1 cycle, p=88, ovf=0. MSUB with the same operands -> p=112.
2. LOAD a=0, b=0, c=0, then 4 consecutive ACC samples a=1000, b=1000 -> p sequence 0, 1000000, 2000000, 3000000, 4000000 on consecutive cycles. A MADD afterwards does not disturb acc: a following ACC 1x1 gives 4000001.
3. Saturation: LOAD a=-2^31, b=-2^31, c=0 (acc=2^62), then ACC with the same operands -> p=2^63-1, ovf=1. ovf stays 1 until ovf_clr=1; with ovf_clr and a new overflow in the same cycle, ovf=1.
4. Instance with SHIFT=4, P_W=16: MADD a=1, b=24, c=0 -> p=2. MADD a=1, b=-24 -> p=-1. MADD a=1, b=2^20 -> p=32767, ovf=1.
5. Stall: 8-sample MADD stream with enable=0 for 3 cycles mid-stream -> the p sequence is identical to the unstalled run, the last result is delayed by exactly 3 cycles, and no duplicate out_valid pulses occur.
6. reset=0 for one cycle while 3 samples are in flight -> next cycle p=0, out_valid=0, ovf=0, acc=0. None of the in-flight results ever appear. A subsequent ACC 2x3 yields p=6.
